// File: rtl/text_vram_arbiter.sv
// Purpose: shares the single-port text VRAM between video character fetches and a host port with posted writes.
// Latency: video data 3 cycles after request; host read data 3 cycles after its slot; host write reaches VRAM >= 2 cycles after acceptance.
// Backpressure: video never stalls; out_host_ready drops while the write FIFO is full or a host read is outstanding.
//
// Ports:
//   in_vga_clock / in_reset_n            clock, asynchronous active-low reset
//   in_vid_req, in_vid_address           video fetch request (one cycle per fetch)
//   out_vid_valid, out_vid_data          video fetch result, fixed 3-cycle latency
//   in_host_req/we/address/wdata         host request, accepted on req & ready
//   out_host_ready                       host may issue a request this cycle
//   out_host_rvalid, out_host_rdata      host read result
//   out_fifo_level                       posted writes still waiting for a slot
//   out_mem_address/wdata/we             registered VRAM port
//   in_mem_rdata                         VRAM read data, one cycle after the address
module text_vram_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          in_vga_clock,
    input  logic                          in_reset_n,
    input  logic                          in_vid_req,
    input  logic [ADDR_WIDTH-1:0]         in_vid_address,
    output logic                          out_vid_valid,
    output logic [DATA_WIDTH-1:0]         out_vid_data,
    input  logic                          in_host_req,
    input  logic                          in_host_we,
    input  logic [ADDR_WIDTH-1:0]         in_host_address,
    input  logic [DATA_WIDTH-1:0]         in_host_wdata,
    output logic                          out_host_ready,
    output logic                          out_host_rvalid,
    output logic [DATA_WIDTH-1:0]         out_host_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   out_fifo_level,
    output logic [ADDR_WIDTH-1:0]         out_mem_address,
    output logic [DATA_WIDTH-1:0]         out_mem_wdata,
    output logic                          out_mem_we,
    input  logic [DATA_WIDTH-1:0]         in_mem_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_READ_WAIT     = 2'd1,
        ST_READ_INFLIGHT = 2'd2
    } rd_state_t;

    // Posted-write FIFO storage and bookkeeping
    wr_entry_t            fifo_mem [FIFO_DEPTH];
    wr_entry_t            fifo_head;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    logic [LVL_W-1:0]     level_nxt;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    // Host read tracking
    rd_state_t            state;
    rd_state_t            state_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                 rd_accept;

    // Slot decision and read-return pipeline
    logic                 issue_vid;
    logic                 issue_wr;
    logic                 issue_rd;
    logic                 vid_d1;
    logic                 vid_d2;
    logic                 rd_d1;
    logic                 rd_d2;
    logic                 ready_q;

    assign fifo_empty = (level == '0);
    assign fifo_head  = fifo_mem[rd_ptr];

    // Ready is registered from next-cycle state, so a pop in the same cycle
    // never reopens a full FIFO, and it stays low during reset.
    assign out_host_ready = ready_q;
    assign push      = in_host_req && ready_q && in_host_we;
    assign rd_accept = in_host_req && ready_q && !in_host_we;

    // Fixed priority: video, then posted writes, then the pending host read.
    // The read waits for an empty FIFO so it observes every earlier write.
    assign issue_vid = in_vid_req;
    assign issue_wr  = !in_vid_req && !fifo_empty;
    assign issue_rd  = !in_vid_req && fifo_empty && (state == ST_READ_WAIT);
    assign pop       = issue_wr;

    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LVL_W'(1);
        end else if (pop && !push) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:          if (rd_accept)       state_nxt = ST_READ_WAIT;
            ST_READ_WAIT:     if (issue_rd)        state_nxt = ST_READ_INFLIGHT;
            ST_READ_INFLIGHT: if (out_host_rvalid) state_nxt = ST_IDLE;
            default:                               state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_vga_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state   <= ST_IDLE;
            rd_addr <= '0;
            ready_q <= 1'b0;
            level   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == ST_IDLE) && (level_nxt != LVL_W'(FIFO_DEPTH));
            level   <= level_nxt;
            if (rd_accept) begin
                rd_addr <= in_host_address;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: the level counter alone says what is valid.
    always_ff @(posedge in_vga_clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: in_host_address, data: in_host_wdata};
        end
    end

    // VRAM port: address holds on idle slots, write enable is a single-cycle pulse.
    always_ff @(posedge in_vga_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            out_mem_address <= '0;
            out_mem_wdata   <= '0;
            out_mem_we      <= 1'b0;
        end else begin
            out_mem_we <= 1'b0;
            if (issue_vid) begin
                out_mem_address <= in_vid_address;
            end else if (issue_wr) begin
                out_mem_address <= fifo_head.addr;
                out_mem_wdata   <= fifo_head.data;
                out_mem_we      <= 1'b1;
            end else if (issue_rd) begin
                out_mem_address <= rd_addr;
            end
        end
    end

    // Return pipeline: address at slot+1, RAM data at slot+2, result at slot+3.
    always_ff @(posedge in_vga_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            vid_d1          <= 1'b0;
            vid_d2          <= 1'b0;
            rd_d1           <= 1'b0;
            rd_d2           <= 1'b0;
            out_vid_valid   <= 1'b0;
            out_vid_data    <= '0;
            out_host_rvalid <= 1'b0;
            out_host_rdata  <= '0;
        end else begin
            vid_d1          <= issue_vid;
            vid_d2          <= vid_d1;
            rd_d1           <= issue_rd;
            rd_d2           <= rd_d1;
            out_vid_valid   <= vid_d2;
            out_host_rvalid <= rd_d2;
            if (vid_d2) begin
                out_vid_data <= in_mem_rdata;
            end
            if (rd_d2) begin
                out_host_rdata <= in_mem_rdata;
            end
        end
    end

    assign out_fifo_level = level;

endmodule

// File: tb/tb_text_vram_arbiter.sv
// Purpose: randomized and directed checks of text_vram_arbiter against a queue-based reference model.
// Latency: outputs compared every cycle on the falling edge against model predictions.
// Backpressure: host acceptance follows the model's own ready prediction.
module tb_text_vram_arbiter;

    localparam int AW = 13;
    localparam int DW = 16;
    localparam int FD = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_valid;
    logic [DW-1:0] vid_data;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ready;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic [LW-1:0] fifo_level;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    text_vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .in_vga_clock    (clk),
        .in_reset_n      (rst_n),
        .in_vid_req      (vid_req),
        .in_vid_address  (vid_addr),
        .out_vid_valid   (vid_valid),
        .out_vid_data    (vid_data),
        .in_host_req     (host_req),
        .in_host_we      (host_we),
        .in_host_address (host_addr),
        .in_host_wdata   (host_wdata),
        .out_host_ready  (host_ready),
        .out_host_rvalid (host_rvalid),
        .out_host_rdata  (host_rdata),
        .out_fifo_level  (fifo_level),
        .out_mem_address (mem_addr),
        .out_mem_wdata   (mem_wdata),
        .out_mem_we      (mem_we),
        .in_mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port VRAM; unwritten words read a fixed pattern.
    logic [DW-1:0] ram     [1<<AW];
    bit            ram_set [1<<AW];

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {3'b101, a} ^ 16'h0F0F;
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            ram_set[mem_addr] <= 1'b1;
        end
        mem_rdata <= ram_set[mem_addr] ? ram[mem_addr] : init_word(mem_addr);
    end

    // Reference model
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } vexp_t;
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic [DW-1:0] mm [1<<AW];
    vexp_t         vq[$];
    wr_t           q[$];
    bit            rd_wait;
    logic [AW-1:0] rd_addr;
    int            rd_due;
    logic [DW-1:0] rd_exp;
    logic [AW-1:0] m_addr;
    bit            m_we;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] last_vid;
    logic [DW-1:0] last_rd;
    bit            m_first;
    int            cyc;
    int            n_cmp;
    int            n_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit model_ready();
        return !m_first && !rd_wait && (rd_due < 0) && (q.size() < FD);
    endfunction

    task automatic model_reset();
        q.delete();
        vq.delete();
        rd_wait  = 1'b0;
        rd_addr  = '0;
        rd_due   = -1;
        rd_exp   = '0;
        m_addr   = '0;
        m_we     = 1'b0;
        m_wdata  = '0;
        last_vid = '0;
        last_rd  = '0;
        m_first  = 1'b1;
    endtask

    task automatic check_outputs();
        bit exp_v;
        bit exp_r;
        check_val("mem_we", 32'(mem_we), 32'(m_we));
        check_val("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (m_we) begin
            check_val("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            mm[m_addr] = m_wdata;
        end
        check_val("fifo_level", 32'(fifo_level), 32'(q.size()));
        check_val("host_ready", 32'(host_ready), 32'(model_ready()));
        exp_v = (vq.size() > 0) && (vq[0].due == cyc);
        check_val("vid_valid", 32'(vid_valid), 32'(exp_v));
        if (exp_v) begin
            last_vid = vq[0].data;
            void'(vq.pop_front());
        end
        check_val("vid_data", 32'(vid_data), 32'(last_vid));
        exp_r = (rd_due == cyc);
        check_val("host_rvalid", 32'(host_rvalid), 32'(exp_r));
        if (exp_r) last_rd = rd_exp;
        check_val("host_rdata", 32'(host_rdata), 32'(last_rd));
    endtask

    // Drive one cycle of inputs and advance the model by the slot rules.
    task automatic step(input bit v, input logic [AW-1:0] va, input bit hr, input bit hw,
                        input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        bit    rdy;
        wr_t   e;
        vexp_t ve;
        rdy        = model_ready();
        vid_req    = v;
        vid_addr   = va;
        host_req   = hr;
        host_we    = hw;
        host_addr  = ha;
        host_wdata = hd;
        m_we = 1'b0;
        if (v) begin
            ve.due  = cyc + 3;
            ve.data = mm[va];
            vq.push_back(ve);
            m_addr = va;
        end else if (q.size() > 0) begin
            e       = q.pop_front();
            m_addr  = e.a;
            m_wdata = e.d;
            m_we    = 1'b1;
        end else if (rd_wait) begin
            rd_wait = 1'b0;
            rd_due  = cyc + 3;
            rd_exp  = mm[rd_addr];
            m_addr  = rd_addr;
        end
        if (hr && rdy) begin
            if (hw) begin
                e.a = ha;
                e.d = hd;
                q.push_back(e);
            end else begin
                rd_wait = 1'b1;
                rd_addr = ha;
            end
        end
        if (rd_due == cyc) rd_due = -1;
        m_first = 1'b0;
    endtask

    task automatic do_cycle(input bit v, input logic [AW-1:0] va, input bit hr, input bit hw,
                            input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        check_outputs();
        step(v, va, hr, hw, ha, hd);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic apply_reset(input bit mid_op);
        rst_n      = 1'b0;
        vid_req    = 1'b0;
        vid_addr   = '0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        if (mid_op) begin
            #1;
            check_val("arst_mem_we", 32'(mem_we), 32'd0);
            check_val("arst_level", 32'(fifo_level), 32'd0);
            check_val("arst_rvalid", 32'(host_rvalid), 32'd0);
            check_val("arst_ready", 32'(host_ready), 32'd0);
        end
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        check_val("rst_vid_valid", 32'(vid_valid), 32'd0);
        check_val("rst_vid_data", 32'(vid_data), 32'd0);
        check_val("rst_ready", 32'(host_ready), 32'd0);
        check_val("rst_rvalid", 32'(host_rvalid), 32'd0);
        check_val("rst_rdata", 32'(host_rdata), 32'd0);
        check_val("rst_level", 32'(fifo_level), 32'd0);
        check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_val("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check_val("rst_mem_we", 32'(mem_we), 32'd0);
        model_reset();
        rst_n = 1'b1;
    endtask

    int pv_tab [8] = '{0, 10, 30, 50, 70, 90, 100, 60};
    int ph_tab [8] = '{80, 50, 90, 30, 100, 60, 70, 40};

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        for (int i = 0; i < (1 << AW); i++) mm[i] = init_word(AW'(i));
        model_reset();
        apply_reset(1'b0);

        // Video only: addresses 0..15 back to back
        for (int i = 0; i < 16; i++) do_cycle(1'b1, AW'(i), 1'b0, 1'b0, '0, '0);
        idle(4);

        // Four posted writes queued behind a video stream, then one rejected attempt
        for (int i = 0; i < 4; i++)
            do_cycle(1'b1, AW'(32 + i), 1'b1, 1'b1, AW'(16 + i), DW'(16'hA000 + i));
        check_val("level_full", 32'(fifo_level), 32'd4);
        check_val("ready_full", 32'(host_ready), 32'd0);
        do_cycle(1'b1, AW'(40), 1'b1, 1'b1, AW'(20), 16'hBEEF);
        idle(8);

        // Collision: two writes while video runs every cycle
        for (int i = 0; i < 10; i++)
            do_cycle(1'b1, AW'(16 + (i % 4)), i < 2, 1'b1, AW'(32 + i), DW'(16'hC000 + i));
        check_val("collision_level", 32'(fifo_level), 32'd2);
        idle(6);

        // Read ordered behind an immediately preceding write
        do_cycle(1'b0, '0, 1'b1, 1'b1, AW'(16'h0100), 16'h1234);
        do_cycle(1'b0, '0, 1'b1, 1'b0, AW'(16'h0100), '0);
        idle(6);
        check_val("order_rdata", 32'(host_rdata), 32'h1234);

        // Read starved by 50 cycles of video
        do_cycle(1'b0, '0, 1'b1, 1'b0, AW'(16'h13), '0);
        for (int i = 0; i < 50; i++) do_cycle(1'b1, AW'($urandom_range(0, 63)), 1'b0, 1'b0, '0, '0);
        idle(6);
        check_val("starve_rdata", 32'(host_rdata), 32'hA003);

        // Randomized traffic with varying video and host load
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 250; i++)
                do_cycle($urandom_range(0, 99) < pv_tab[s], AW'($urandom_range(0, 63)),
                         $urandom_range(0, 99) < ph_tab[s], $urandom_range(0, 99) < 65,
                         AW'($urandom_range(0, 63)), DW'($urandom));
            idle(10);
        end

        // Reset with three writes queued and a read pending
        for (int i = 0; i < 3; i++)
            do_cycle(1'b1, AW'(i), 1'b1, 1'b1, AW'(48 + i), DW'(16'hD000 + i));
        do_cycle(1'b1, AW'(3), 1'b1, 1'b0, AW'(48), '0);
        do_cycle(1'b1, AW'(4), 1'b0, 1'b0, '0, '0);
        check_val("pre_rst_level", 32'(fifo_level), 32'd3);
        apply_reset(1'b1);
        idle(10);
        check_val("post_rst_rdata", 32'(host_rdata), 32'd0);

        // Traffic after reset, including reads of addresses whose writes were flushed
        for (int i = 0; i < 300; i++)
            do_cycle($urandom_range(0, 99) < 40, AW'($urandom_range(40, 63)),
                     $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                     AW'($urandom_range(40, 63)), DW'($urandom));
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
